// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
// Two-direction traffic light sequencer with a seconds prescaler, per-direction
// remaining-time countdowns, a pedestrian green cut and a night flash mode.
//
// Ports:
//   clk       - single clock, rising edge
//   rs        - synchronous active-high reset
//   ped_req   - pedestrian request (pulse or level), latched on any cycle
//   flash_en  - night flash mode request (level), acted on at tick
//   X1/V1/D1  - direction-1 green / yellow / red
//   X2/V2/D2  - direction-2 green / yellow / red
//   cnt1/cnt2 - ticks remaining until the direction's light changes (0 in flash)
//   tick      - prescaler strobe, high for one clk per tick
module traffic_light_ctrl #(
   parameter int CNT_W    = 8,
   parameter int T_G1     = 15,
   parameter int T_G2     = 20,
   parameter int T_Y      = 5,
   parameter int T_PED    = 3,
   parameter int TICK_DIV = 1
) (
   input  logic             clk,
   input  logic             rs,
   input  logic             ped_req,
   input  logic             flash_en,
   output logic             X1,
   output logic             V1,
   output logic             D1,
   output logic             X2,
   output logic             V2,
   output logic             D2,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic             tick
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   localparam logic [CNT_W-1:0] LD_G1  = CNT_W'(T_G1 - 1);
   localparam logic [CNT_W-1:0] LD_G2  = CNT_W'(T_G2 - 1);
   localparam logic [CNT_W-1:0] LD_Y   = CNT_W'(T_Y - 1);
   localparam logic [CNT_W-1:0] LD_PED = CNT_W'(T_PED - 1);
   localparam logic [CNT_W-1:0] ADD_Y  = CNT_W'(T_Y);

   typedef enum logic [2:0] {
      S0, // dir1 green,  dir2 red
      S1, // dir1 yellow, dir2 red
      S2, // dir1 red,    dir2 green
      S3, // dir1 red,    dir2 yellow
      SF  // night flash
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [DIV_W-1:0] div;
   logic             blink;
   logic             ped_pend;

   assign tick = (div == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rs) begin
         state    <= S0;
         count    <= LD_G1;
         div      <= '0;
         blink    <= 1'b0;
         ped_pend <= 1'b0;
      end else begin
         div <= tick ? '0 : div + 1'b1;

         if (tick) begin
            if (flash_en) begin
               if (state == SF) begin
                  blink <= ~blink;
               end else begin
                  state <= SF;
                  blink <= 1'b0;
               end
            end else if (state == SF) begin
               state    <= S0;
               count    <= LD_G1;
               ped_pend <= 1'b0;
            end else if (count == '0) begin
               case (state)
                  S0: begin
                     state    <= S1;
                     count    <= LD_Y;
                     ped_pend <= 1'b0;
                  end
                  S1: begin
                     state <= S2;
                     count <= LD_G2;
                  end
                  S2: begin
                     state    <= S3;
                     count    <= LD_Y;
                     ped_pend <= 1'b0;
                  end
                  default: begin
                     state <= S0;
                     count <= LD_G1;
                  end
               endcase
            end else if ((state == S0 || state == S2) && ped_pend && (count > LD_PED)) begin
               count    <= LD_PED;
               ped_pend <= 1'b0;
            end else begin
               count <= count - 1'b1;
            end
         end

         // Placed after the clears so a coincident request survives for the next green.
         if (ped_req) begin
            ped_pend <= 1'b1;
         end
      end
   end

   always_comb begin
      {X1, V1, D1, X2, V2, D2} = '0;
      cnt1 = '0;
      cnt2 = '0;
      case (state)
         S0: begin
            X1   = 1'b1;
            D2   = 1'b1;
            cnt1 = count + 1'b1;
            cnt2 = count + 1'b1 + ADD_Y;
         end
         S1: begin
            V1   = 1'b1;
            D2   = 1'b1;
            cnt1 = count + 1'b1;
            cnt2 = count + 1'b1;
         end
         S2: begin
            D1   = 1'b1;
            X2   = 1'b1;
            cnt1 = count + 1'b1 + ADD_Y;
            cnt2 = count + 1'b1;
         end
         S3: begin
            D1   = 1'b1;
            V2   = 1'b1;
            cnt1 = count + 1'b1;
            cnt2 = count + 1'b1;
         end
         SF: begin
            V1 = blink;
            V2 = blink;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised two-direction traffic light controller. It sequences green, yellow and red for direction 1 and direction 2 with independently configurable phase durations. It adds an internal seconds prescaler, per-direction remaining-time countdown outputs for the LCD counter path, a pedestrian request that shortens the active green, and a night flash mode. It sits between the board clock and the LED/LCD display drivers.

## Interface
Parameters:
- CNT_W, 8, width of phase counter and countdown outputs
- T_G1, 15, direction-1 green duration in ticks
- T_G2, 20, direction-2 green duration in ticks
- T_Y, 5, yellow duration in ticks (both directions)
- T_PED, 3, green remaining after a pedestrian cut, in ticks
- TICK_DIV, 1, clk cycles per tick (≥1)
- Legal settings: 1 ≤ T_PED ≤ min(T_G1, T_G2), T_Y ≥ 1, max(T_G1, T_G2) + T_Y ≤ 2^CNT_W − 1.

Ports:
- clk  in  1  single clock, rising edge
- rs  in  1  synchronous active-high reset
- ped_req  in  1  pedestrian request (pulse or level)
- flash_en  in  1  night flash mode request (level)
- X1, V1, D1  out  1 each  direction-1 green / yellow / red
- X2, V2, D2  out  1 each  direction-2 green / yellow / red
- cnt1  out  CNT_W  direction-1 ticks remaining until its light changes
- cnt2  out  CNT_W  direction-2 ticks remaining until its light changes
- tick  out  1  prescaler strobe (high for 1 clk per tick)

## Operation
- Prescaler div counts 0..TICK_DIV−1 and wraps. tick = (div == TICK_DIV−1). With TICK_DIV=1, tick is constantly 1.
- State, count, blink and ped_pend update only on tick cycles. The exceptions are rs, and ped_pend set, which happens on any cycle.
- States and their lights:
  - S0 (dir1 green, dir2 red): X1, D2 high.
  - S1 (dir1 yellow, dir2 red): V1, D2 high.
  - S2 (dir1 red, dir2 green): D1, X2 high.
  - S3 (dir1 red, dir2 yellow): D1, V2 high.
  - SF (flash): V1 = V2 = blink; all other lights 0.
- On entering a state, count loads duration−1. On each tick: if count == 0, go to the next state; else count decrements.
  - Sequence: S0 → S1 → S2 → S3 → S0.
  - Load values: S1 and S3 load T_Y−1, S2 loads T_G2−1, S0 loads T_G1−1.
  - Each state therefore lasts exactly its duration in ticks.
- Pedestrian handling:
  - ped_req = 1 in any cycle sets ped_pend.
  - On a tick in S0 or S2 with ped_pend = 1 and count > T_PED−1: count loads T_PED−1 and ped_pend clears.
  - ped_pend also clears when S1 or S3 is entered.
  - If ped_req coincides with a clear, set wins and the request applies to the next green.
  - A request during S1, S3 or SF is held until the next green.
- Flash mode:
  - On a tick with flash_en = 1, any state goes to SF and blink loads 0.
  - In SF, blink toggles every tick.
  - On a tick in SF with flash_en = 0: go to S0, count loads T_G1−1, ped_pend clears.
  - flash_en has priority over normal transitions and over the pedestrian cut.
- Countdown outputs are combinational from state and count, computed in CNT_W bits (no overflow under legal parameters):
  - cnt1 = count+1 in S0, S1, S3; count+1+T_Y in S2.
  - cnt2 = count+1 in S1, S2, S3; count+1+T_Y in S0.
  - In SF: cnt1 = cnt2 = 0.
- Lights are decoded combinationally from the state register. Exactly one light per direction is high outside SF.

## Timing
- rs sampled high at a clk edge sets: state = S0, count = T_G1−1, div = 0, blink = 0, ped_pend = 0. rs overrides all other inputs.
- Outputs after reset:
  - X1 = 1, D2 = 1, all other lights 0.
  - cnt1 = T_G1, cnt2 = T_G1+T_Y.
  - tick = (TICK_DIV == 1).
- Reset asserted mid-phase, including in SF, returns to these values on the next edge.
- Light and count changes become visible one clk after the tick cycle that caused them.
- Full normal cycle = T_G1 + T_Y + T_G2 + T_Y ticks (45 with defaults).

## Test plan
- Reset, then run 45 ticks with defaults (TICK_DIV = 1):
  - X1 high for 15 cycles, V1 for 5, D1 for 25.
  - cnt1 counts 15..1, then 5..1, then 25..1.
  - cnt2 starts at 20 and reaches 1 when S2 begins.
- TICK_DIV = 4: tick high every 4th clk. S0 lasts 60 clks. cnt1 holds each value for 4 clks.
- Pulse ped_req at S0 with cnt1 = 12:
  - cnt1 goes 3, 2, 1, then S1.
  - Repeat the pulse at cnt1 = 2: no cut, pending clears on S1 entry.
- Pulse ped_req during S1: the cut applies in S2, and cnt2 goes to 3 on the first S2 tick.
- Raise flash_en in S2:
  - Next tick: SF, all lights 0 except V1 = V2 = 0, then 1, 0, 1 on successive ticks.
  - cnt1 = cnt2 = 0.
  - Drop flash_en: next tick gives S0 with cnt1 = 15.
- Assert rs for one cycle mid-S3 with ped_pend set: next cycle is the reset state, and a following S0 runs its full 15 ticks.
